leak_monitor: RTL and testbench
===============================

LEAK_MONITOR -- requirements
Module: leak_monitor

Interface
REQ-001 SHALL provide parameter: WIN_LOG2, 8, log2 of window length N (N = 2^WIN_LOG2 samples).
REQ-002 SHALL provide parameter: THRESH, 16, per-bit toggle count at or above which the bit alarms.
REQ-003 SHALL have port: clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port: start  input  1  begin one measurement window (sampled in IDLE only).
REQ-006 SHALL have port: cont  input  1  continuous mode; sampled at the output handshake.
REQ-007 SHALL have port: cap_in  input  8  capacitance leakage bus from the trojan-instrumented AES top.
REQ-008 SHALL have port: out_ready  input  1  consumer accepts the result.
REQ-009 SHALL have port: out_valid  output  1  result record valid.
REQ-010 SHALL have port: alarm  output  8  bit i = 1 when toggle count of cap_in[i] >= THRESH.
REQ-011 SHALL have port: total  output  WIN_LOG2+4  sum of all 8 per-bit toggle counts.
REQ-012 SHALL have port: hot_bit  output  3  index of bit with the highest toggle count.
REQ-013 SHALL have port: busy  output  1  high in any state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, PRIME, COUNT, REPORT.
REQ-015 IDLE: start=1 -> PRIME; else stay.
REQ-016 PRIME (one cycle): load prev <= cap_in; clear all 8 counters and window counter; -> COUNT.
REQ-017 COUNT: every cycle, per bit i, cnt[i] += (cap_in[i] != prev[i]); prev <= cap_in; window counter increments.
REQ-018 COUNT SHALL last exactly N cycles (N comparisons), then -> REPORT.
REQ-019 Per-bit counters SHALL be WIN_LOG2+1 bits wide; max value N; they SHALL never wrap.
REQ-020 On the COUNT -> REPORT edge, alarm, total and hot_bit SHALL be registered from the final counts, including the last sample.
REQ-021 hot_bit ties SHALL resolve to the lowest index; all counts zero -> hot_bit = 0.
REQ-022 REPORT: out_valid = 1; alarm/total/hot_bit SHALL hold stable until out_valid && out_ready.
REQ-023 Handshake in REPORT with cont=1 -> PRIME; with cont=0 -> IDLE.
REQ-024 out_valid SHALL rise N+2 clock edges after the edge that samples start in IDLE.
REQ-025 start SHALL be ignored outside IDLE.
REQ-026 cap_in SHALL be ignored in IDLE and REPORT.
REQ-027 out_valid SHALL be 0 in every state except REPORT.
REQ-028 out_ready SHALL be ignored outside REPORT.

Reset
REQ-029 rst=1 at any clock edge, including mid-COUNT or mid-REPORT, SHALL force IDLE and abandon any partial result.
REQ-030 rst SHALL clear: out_valid=0, busy=0, alarm=0x00, total=0, hot_bit=0, prev=0x00, and all counters to 0.
REQ-031 rst SHALL take priority over start and the output handshake.

Verification (WIN_LOG2=2, N=4, THRESH=2)
REQ-032 Single window:
- stimulus: start pulse; cap_in = 0x00 in PRIME; then 0x01,0x00,0x01,0x00 in COUNT.
- response: out_valid 6 edges after start; alarm=0x01, total=4, hot_bit=0.
REQ-033 Multi-bit window:
- stimulus: cap_in constant 0x80 through PRIME, then 0x80,0x81,0x03,0x03.
- response: counts b7=1, b0=1, b1=1; alarm=0x00, total=3, hot_bit=0.
REQ-034 Backpressure:
- stimulus: out_ready held 0 for 10 cycles in REPORT while cap_in and start toggle.
- response: outputs unchanged and out_valid=1 throughout; on out_ready=1, IDLE next cycle and busy=0.
REQ-035 Continuous mode:
- stimulus: cont=1 at handshake; second window cap_in = 0xFF,0x00,0xFF,0x00,0xFF.
- response: PRIME immediately, no IDLE cycle; second report alarm=0xFF, total=32, hot_bit=0.
REQ-036 Reset mid-COUNT:
- stimulus: rst=1 on the 2nd COUNT cycle.
- response: next cycle IDLE, busy=0, out_valid=0, all outputs zero; a fresh start gives a correct independent result.

Source files
------------

// File: rtl/leak_monitor.sv
// Leakage monitor: counts per-bit toggles of cap_in over a window of 2^WIN_LOG2
// comparisons, then reports alarm bits, total toggle count and the hottest bit.
module leak_monitor #(
    parameter int WIN_LOG2 = 8,
    parameter int THRESH   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                cont,
    input  logic [7:0]          cap_in,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [7:0]          alarm,
    output logic [WIN_LOG2+3:0] total,
    output logic [2:0]          hot_bit,
    output logic                busy
);

    localparam int CW = WIN_LOG2 + 1;
    localparam int TW = WIN_LOG2 + 4;
    localparam logic [CW-1:0] N_CNT = {1'b1, {WIN_LOG2{1'b0}}};

    typedef enum logic [1:0] {IDLE, PRIME, COUNT, REPORT} state_t;

    state_t        state_reg;
    logic [7:0]    prev_reg;
    logic [CW-1:0] cnt_reg [8];
    logic [CW-1:0] win_reg;
    logic          out_valid_reg;
    logic          busy_reg;
    logic [7:0]    alarm_reg;
    logic [TW-1:0] total_reg;
    logic [2:0]    hot_reg;

    logic [7:0]    toggle;
    logic [7:0]    alarm_next;
    logic [TW-1:0] total_next;
    logic [2:0]    hot_next;
    logic [CW-1:0] best;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_toggle
            assign toggle[gi] = cap_in[gi] ^ prev_reg[gi];
        end
    endgenerate

    // Strict '>' keeps the lowest index on ties; all-zero counts give index 0.
    always_comb begin
        alarm_next = '0;
        total_next = '0;
        hot_next   = '0;
        best       = cnt_reg[0];
        for (int i = 0; i < 8; i++) begin
            total_next    = total_next + TW'(cnt_reg[i]);
            alarm_next[i] = (int'(cnt_reg[i]) >= THRESH);
        end
        for (int i = 1; i < 8; i++) begin
            if (cnt_reg[i] > best) begin
                best     = cnt_reg[i];
                hot_next = 3'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            prev_reg      <= '0;
            win_reg       <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            alarm_reg     <= '0;
            total_reg     <= '0;
            hot_reg       <= '0;
            for (int i = 0; i < 8; i++) cnt_reg[i] <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= PRIME;
                        busy_reg  <= 1'b1;
                    end
                end
                PRIME: begin
                    prev_reg  <= cap_in;
                    win_reg   <= '0;
                    for (int i = 0; i < 8; i++) cnt_reg[i] <= '0;
                    state_reg <= COUNT;
                end
                COUNT: begin
                    // N comparison cycles, then one cycle to latch the final counts.
                    if (win_reg != N_CNT) begin
                        for (int i = 0; i < 8; i++)
                            cnt_reg[i] <= cnt_reg[i] + CW'(toggle[i]);
                        prev_reg <= cap_in;
                        win_reg  <= win_reg + 1'b1;
                    end else begin
                        alarm_reg     <= alarm_next;
                        total_reg     <= total_next;
                        hot_reg       <= hot_next;
                        out_valid_reg <= 1'b1;
                        state_reg     <= REPORT;
                    end
                end
                REPORT: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        if (cont) begin
                            state_reg <= PRIME;
                        end else begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign alarm     = alarm_reg;
    assign total     = total_reg;
    assign hot_bit   = hot_reg;

endmodule

// File: tb/tb_leak_monitor.sv
// Scoreboard bench for leak_monitor (N=4, THRESH=2): stimulus pushes expected
// reports, a negedge monitor compares them whenever out_valid is high.
module tb_leak_monitor;

    localparam int WIN_LOG2 = 2;
    localparam int THRESH   = 2;

    logic       clk = 1'b0;
    logic       rst, start, cont, out_ready;
    logic [7:0] cap_in;
    logic       out_valid, busy;
    logic [7:0] alarm;
    logic [WIN_LOG2+3:0] total;
    logic [2:0] hot_bit;

    typedef struct {
        logic [7:0] alarm;
        int         total;
        int         hot;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    leak_monitor #(.WIN_LOG2(WIN_LOG2), .THRESH(THRESH)) dut (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .cap_in(cap_in),
        .out_ready(out_ready), .out_valid(out_valid), .alarm(alarm),
        .total(total), .hot_bit(hot_bit), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: count bit flips between consecutive samples of the window.
    function automatic exp_t model(input logic [7:0] vals [5]);
        exp_t e;
        int   cnt [8];
        int   best;
        e.alarm = '0; e.total = 0; e.hot = 0; best = 0;
        for (int b = 0; b < 8; b++) begin
            cnt[b] = 0;
            for (int k = 1; k < 5; k++)
                if (vals[k][b] != vals[k-1][b]) cnt[b]++;
            e.total += cnt[b];
            if (cnt[b] >= THRESH) e.alarm[b] = 1'b1;
            if (cnt[b] > best) begin
                best  = cnt[b];
                e.hot = b;
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                chk("alarm", int'(alarm), int'(q[0].alarm));
                chk("total", int'(total), q[0].total);
                chk("hot_bit", int'(hot_bit), q[0].hot);
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    // Runs one window. from_cont: the DUT is already in PRIME after a cont handshake.
    task automatic do_window(input logic [7:0] vals [5], input bit from_cont,
                             input int delay, input bit cont_next);
        int edges;
        exp_t e;
        e = model(vals);
        q.push_back(e);
        $display("window %02h %02h %02h %02h %02h cont_in=%0d -> alarm=%02h total=%0d hot=%0d",
                 vals[0], vals[1], vals[2], vals[3], vals[4], from_cont, e.alarm, e.total, e.hot);
        if (!from_cont) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        chk("busy_prime", int'(busy), 1);
        chk("valid_prime", int'(out_valid), 0);
        for (int k = 0; k < 5; k++) begin
            cap_in = vals[k];
            tick();
        end
        edges  = 5;
        cap_in = 8'($urandom);
        while (!out_valid && edges < 20) begin
            tick();
            edges++;
        end
        chk("latency", edges, 6);
        for (int d = 0; d < delay; d++) begin
            cap_in = 8'($urandom);
            start  = 1'($urandom);
            cont   = 1'($urandom);
            tick();
            chk("valid_hold", int'(out_valid), 1);
            chk("busy_hold", int'(busy), 1);
        end
        start     = 1'b0;
        cont      = cont_next;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        cont      = 1'b0;
        chk("valid_after_hs", int'(out_valid), 0);
        chk("busy_after_hs", int'(busy), cont_next ? 1 : 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] v [5];
        bit from_cont;
        bit cn;

        rst = 1'b1; start = 1'b0; cont = 1'b0; out_ready = 1'b0; cap_in = 8'h00;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_alarm", int'(alarm), 0);
        chk("rst_total", int'(total), 0);
        chk("rst_hot", int'(hot_bit), 0);

        // Single toggling bit
        v = '{8'h00, 8'h01, 8'h00, 8'h01, 8'h00};
        do_window(v, 1'b0, 0, 1'b0);
        // Several bits, one toggle each
        v = '{8'h80, 8'h80, 8'h81, 8'h03, 8'h03};
        do_window(v, 1'b0, 1, 1'b0);
        // Backpressure for 10 cycles, then continuous mode into an all-bits window
        v = '{8'h3C, 8'h30, 8'h0C, 8'h3C, 8'h00};
        do_window(v, 1'b0, 10, 1'b1);
        v = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF};
        do_window(v, 1'b1, 0, 1'b0);
        chk("idle_busy", int'(busy), 0);

        // Reset on the second COUNT edge abandons the window
        start = 1'b1; tick(); start = 1'b0;
        cap_in = 8'h00; tick();
        cap_in = 8'hFF; tick();
        cap_in = 8'h00; rst = 1'b1; tick(); rst = 1'b0;
        $display("reset mid-COUNT");
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_alarm", int'(alarm), 0);
        chk("midrst_total", int'(total), 0);
        chk("midrst_hot", int'(hot_bit), 0);
        tick();
        v = '{8'h0F, 8'hF0, 8'hF0, 8'h00, 8'h40};
        do_window(v, 1'b0, 2, 1'b0);

        // Randomized windows, mixing sparse and dense toggling
        from_cont = 1'b0;
        for (int w = 0; w < 40; w++) begin
            for (int k = 0; k < 5; k++)
                v[k] = (w % 2 == 0) ? 8'($urandom) : (8'($urandom) & 8'($urandom));
            cn = (w == 39) ? 1'b0 : 1'($urandom);
            do_window(v, from_cont, $urandom_range(0, 3), cn);
            from_cont = cn;
        end

        tick();
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
